// File: rtl/seq_run_detector.sv
// Per-channel detector for runs of consecutive 1s with wrap or saturate at RUN_LEN.
// Optional per-channel saturating hit counters are enabled with SEQ_RUN_HIT_COUNT_EN.
//
//  s             | meaning
//  0             | no run in progress (last accepted bit was 0, or cleared)
//  1..RUN_LEN-1  | run of s consecutive 1s, not yet complete
//  RUN_LEN       | completed run; next 1 wraps to 1 or holds, per WRAP_MODE
module seq_run_detector #(
   parameter int NUM_CH    = 1,
   parameter int RUN_LEN   = 3,
   parameter int WRAP_MODE = 1,
   parameter int HC_W      = 8,
   localparam int CNT_W    = $clog2(RUN_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic [NUM_CH-1:0]       in,
   output logic [NUM_CH*CNT_W-1:0] state,
   output logic [NUM_CH-1:0]       hit
`ifdef SEQ_RUN_HIT_COUNT_EN
   ,
   output logic [NUM_CH*HC_W-1:0]  hit_count
`endif
);

   if (RUN_LEN < 2) begin : g_bad_run_len
      $error("seq_run_detector: RUN_LEN must be >= 2");
   end
   if (HC_W < 1) begin : g_bad_hc_w
      $error("seq_run_detector: HC_W must be >= 1");
   end

   localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
   localparam logic [CNT_W-1:0] RUN_PRE  = CNT_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] WRAP_VAL = (WRAP_MODE != 0) ? CNT_W'(1) : CNT_W'(RUN_LEN);

   logic [NUM_CH*CNT_W-1:0] state_nxt;
   logic [NUM_CH-1:0]       hit_nxt;
   logic [CNT_W-1:0]        s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= '0;
         hit   <= '0;
      end else begin
         state <= state_nxt;
         hit   <= hit_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hit_nxt   = '0;
      s         = '0;
      if (clear) begin
         state_nxt = '0;
      end else if (in_valid) begin
         for (int i = 0; i < NUM_CH; i++) begin
            s = state[i*CNT_W +: CNT_W];
            if (!in[i]) begin
               state_nxt[i*CNT_W +: CNT_W] = '0;
            end else if (s == RUN_MAX) begin
               state_nxt[i*CNT_W +: CNT_W] = WRAP_VAL;
            end else begin
               state_nxt[i*CNT_W +: CNT_W] = s + CNT_W'(1);
            end
            hit_nxt[i] = in[i] && (s == RUN_PRE);
         end
      end
   end

`ifdef SEQ_RUN_HIT_COUNT_EN
   logic [NUM_CH*HC_W-1:0] hc_nxt;

   // Counters key off hit_nxt so the count lands on the same edge as the hit pulse.
   always_comb begin
      hc_nxt = hit_count;
      if (clear) begin
         hc_nxt = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit_nxt[i] && (hit_count[i*HC_W +: HC_W] != {HC_W{1'b1}})) begin
               hc_nxt[i*HC_W +: HC_W] = hit_count[i*HC_W +: HC_W] + HC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_count <= '0;
      end else begin
         hit_count <= hc_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench: a 2-channel wrap-mode detector and a 1-channel saturate-mode
// detector share clear/in_valid; the saturating one sees channel 0's input.
module tb_seq_run_detector;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic       in_valid;
   logic [1:0] in_w;
   logic [3:0] st_w;
   logic [1:0] hit_w;
   logic [1:0] st_s;
   logic       hit_s;
`ifdef SEQ_RUN_HIT_COUNT_EN
   logic [3:0] hc_w;
   logic [1:0] hc_s;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_run_detector #(.NUM_CH(2), .RUN_LEN(3), .WRAP_MODE(1), .HC_W(2)) u_wrap (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in       (in_w),
      .state    (st_w),
      .hit      (hit_w)
`ifdef SEQ_RUN_HIT_COUNT_EN
      ,
      .hit_count(hc_w)
`endif
   );

   seq_run_detector #(.NUM_CH(1), .RUN_LEN(3), .WRAP_MODE(0), .HC_W(2)) u_sat (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in       (in_w[0]),
      .state    (st_s),
      .hit      (hit_s)
`ifdef SEQ_RUN_HIT_COUNT_EN
      ,
      .hit_count(hc_s)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check wrap ch0, wrap ch1, saturate ch0 state and hit.
   task automatic chk_all(input string tag, input int w0, input int wh0,
                          input int w1, input int wh1, input int s0, input int sh0);
      chk({tag, " w0.state"}, int'(st_w[1:0]), w0);
      chk({tag, " w0.hit"},   int'(hit_w[0]),  wh0);
      chk({tag, " w1.state"}, int'(st_w[3:2]), w1);
      chk({tag, " w1.hit"},   int'(hit_w[1]),  wh1);
      chk({tag, " s0.state"}, int'(st_s),      s0);
      chk({tag, " s0.hit"},   int'(hit_s),     sh0);
   endtask

   int exp_wrap [5] = '{1, 2, 3, 1, 2};
   int exp_sat  [5] = '{1, 2, 3, 3, 3};
   int exp_hit  [5] = '{0, 0, 1, 0, 0};
   int gap_vld  [5] = '{1, 1, 0, 0, 1};
   int gap_st   [5] = '{1, 2, 2, 2, 3};
   int gap_hit  [5] = '{0, 0, 0, 0, 1};

   initial begin
      reset_n  = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_w     = 2'b00;
      #12;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      step();
      step();
      reset_n = 1'b1;

      // Continuous 1s on ch0: wrap vs saturate.
      in_valid = 1'b1;
      in_w     = 2'b01;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_all($sformatf("run%0d", k), exp_wrap[k], exp_hit[k], 0, 0, exp_sat[k], exp_hit[k]);
      end
      in_w = 2'b00;
      step();
      chk_all("run_zero", 0, 0, 0, 0, 0, 0);

      // in_valid gaps hold the run.
      for (int k = 0; k < 5; k++) begin
         in_valid = gap_vld[k][0];
         in_w     = 2'b01;
         step();
         chk_all($sformatf("gap%0d", k), gap_st[k], gap_hit[k], 0, 0, gap_st[k], gap_hit[k]);
      end
      in_valid = 1'b1;
      in_w     = 2'b00;
      step();
      chk_all("gap_zero", 0, 0, 0, 0, 0, 0);

      // clear beats an accepted 1 that would complete the run.
      in_w = 2'b01;
      step();
      step();
      chk_all("pre_clear", 2, 0, 0, 0, 2, 0);
      clear = 1'b1;
      step();
      chk_all("clear", 0, 0, 0, 0, 0, 0);
`ifdef SEQ_RUN_HIT_COUNT_EN
      chk("clear hc_w", int'(hc_w), 0);
      chk("clear hc_s", int'(hc_s), 0);
`endif
      clear = 1'b0;

      // Independent channels: ch0 all 1s, ch1 alternating 1/0.
      for (int k = 0; k < 12; k++) begin
         in_w = {1'(k % 2 == 0), 1'b1};
         step();
         chk_all($sformatf("ind%0d", k),
                 (k % 3) + 1, int'(k % 3 == 2),
                 (k % 2 == 0) ? 1 : 0, 0,
                 (k < 3) ? k + 1 : 3, int'(k == 2));
`ifdef SEQ_RUN_HIT_COUNT_EN
         if (k == 2) chk("ind hc0 first", int'(hc_w[1:0]), 1);
`endif
      end
`ifdef SEQ_RUN_HIT_COUNT_EN
      chk("hc ch0 sat", int'(hc_w[1:0]), 3);
      chk("hc ch1",     int'(hc_w[3:2]), 0);
      chk("hc sat dut", int'(hc_s),      1);
`endif

      // Asynchronous reset between edges while hit is high and runs are active.
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0, 0);
`ifdef SEQ_RUN_HIT_COUNT_EN
      chk("async_reset hc_w", int'(hc_w), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
